game_countdown_timer: RTL and testbench

Round countdown timer for the game screen. It consumes the slow-clock tick (one_sec pulse) and the 50%-duty blink signal (duty50) from the one-second counter stage. It keeps the remaining round time, presents it as four BCD digits (mm:ss) for the score/HUD drawing and seven-segment logic, and flags the warning window and expiry. Start, pause and bonus-time inputs come from the game controller.

---
 rtl/game_timer_pkg.sv | 7 +
 rtl/seconds_to_mmss_bcd.sv | 18 +
 rtl/game_countdown_timer.sv | 88 ++++++++
 tb/tb_game_countdown_timer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared types and limits for the round countdown timer
package game_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam int MAX_SECONDS = 5999;
  localparam int SEC_W = 13;
endpackage

// File: rtl/seconds_to_mmss_bcd.sv
// seconds_to_mmss_bcd: combinational split of a seconds count into mm:ss BCD digits
module seconds_to_mmss_bcd
  import game_timer_pkg::*;
(
  input  logic [SEC_W-1:0] seconds_i,
  output bcd_digit_t       min_tens_o,
  output bcd_digit_t       min_ones_o,
  output bcd_digit_t       sec_tens_o,
  output bcd_digit_t       sec_ones_o
);
  logic [SEC_W-1:0] mins, secs;
  assign mins       = seconds_i / SEC_W'(60);
  assign secs       = seconds_i % SEC_W'(60);
  assign min_tens_o = bcd_digit_t'(mins / SEC_W'(10));
  assign min_ones_o = bcd_digit_t'(mins % SEC_W'(10));
  assign sec_tens_o = bcd_digit_t'(secs / SEC_W'(10));
  assign sec_ones_o = bcd_digit_t'(secs % SEC_W'(10));
endmodule

// File: rtl/game_countdown_timer.sv
// game_countdown_timer: round countdown with pause, bonus time, warning and expiry flags
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int INIT_SECONDS  = 120,
  parameter int WARN_SECONDS  = 10,
  parameter int BONUS_SECONDS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       add_bonus,
  input  logic       one_sec,
  input  logic       duty50,
  output bcd_digit_t min_tens,
  output bcd_digit_t min_ones,
  output bcd_digit_t sec_tens,
  output bcd_digit_t sec_ones,
  output logic       running,
  output logic       expired,
  output logic       time_up,
  output logic       warning,
  output logic       blink
);
  timer_state_t     state_q, state_d;
  logic [SEC_W-1:0] count_q, count_d;
  logic [SEC_W:0]   sum;
  logic             dec, bon, warn_d;
  bcd_digit_t       mt_d, mo_d, st_d, so_d;
  bcd_digit_t       mt_q, mo_q, st_q, so_q;
  logic             running_q, expired_q, time_up_q, warning_q;
  always_comb begin
    dec     = state_q == RUN && one_sec && !pause && !start && count_q != '0;
    bon     = (state_q == RUN || state_q == PAUSED) && add_bonus && !start;
    // bonus and tick fold into one saturating update
    sum     = {1'b0, count_q} + (bon ? (SEC_W+1)'(BONUS_SECONDS) : '0) - (SEC_W+1)'(dec);
    count_d = start ? SEC_W'(INIT_SECONDS) :
              sum > (SEC_W+1)'(MAX_SECONDS) ? SEC_W'(MAX_SECONDS) : sum[SEC_W-1:0];
    state_d = start                                ? RUN     :
              (state_q == RUN && count_d == '0)    ? EXPIRED :
              (state_q == RUN && pause)            ? PAUSED  :
              (state_q == PAUSED && !pause)        ? RUN     : state_q;
    warn_d  = (state_d == RUN || state_d == PAUSED) && count_d != '0 &&
              count_d <= SEC_W'(WARN_SECONDS);
  end
  seconds_to_mmss_bcd u_conv (
    .seconds_i  (count_d),
    .min_tens_o (mt_d),
    .min_ones_o (mo_d),
    .sec_tens_o (st_d),
    .sec_ones_o (so_d)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mt_q      <= '0;
      mo_q      <= '0;
      st_q      <= '0;
      so_q      <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
      warning_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mt_q      <= mt_d;
      mo_q      <= mo_d;
      st_q      <= st_d;
      so_q      <= so_d;
      running_q <= state_d == RUN;
      expired_q <= state_d == EXPIRED;
      time_up_q <= state_q == RUN && state_d == EXPIRED;
      warning_q <= warn_d;
    end
  end
  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign time_up  = time_up_q;
  assign warning  = warning_q;
  assign blink    = warning_q & duty50;
endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer: directed checks of a 120 s timer and a 3 s timer sharing stimulus
module tb_game_countdown_timer;
  import game_timer_pkg::*;
  logic clk = 0, reset = 1, start = 0, pause = 0, add_bonus = 0, one_sec = 0, duty50 = 0;
  bcd_digit_t a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic a_run, a_exp, a_tu, a_warn, a_blink, b_run, b_exp, b_tu, b_warn, b_blink;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  game_countdown_timer #(.INIT_SECONDS(120), .WARN_SECONDS(10), .BONUS_SECONDS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .add_bonus(add_bonus),
    .one_sec(one_sec), .duty50(duty50), .min_tens(a_mt), .min_ones(a_mo),
    .sec_tens(a_st), .sec_ones(a_so), .running(a_run), .expired(a_exp),
    .time_up(a_tu), .warning(a_warn), .blink(a_blink));
  game_countdown_timer #(.INIT_SECONDS(3), .WARN_SECONDS(10), .BONUS_SECONDS(5)) dut3 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .add_bonus(add_bonus),
    .one_sec(one_sec), .duty50(duty50), .min_tens(b_mt), .min_ones(b_mo),
    .sec_tens(b_st), .sec_ones(b_so), .running(b_run), .expired(b_exp),
    .time_up(b_tu), .warning(b_warn), .blink(b_blink));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one-cycle pulse launched and retired on falling edges
  task automatic pulse(input logic s, input logic b, input logic t);
    @(negedge clk);
    start = s; add_bonus = b; one_sec = t;
    @(negedge clk);
    start = 0; add_bonus = 0; one_sec = 0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(0, 0, 1);
  endtask
  function automatic logic [15:0] a_dig();
    return {a_mt, a_mo, a_st, a_so};
  endfunction
  function automatic logic [15:0] b_dig();
    return {b_mt, b_mo, b_st, b_so};
  endfunction
  initial begin
    repeat (3) @(negedge clk);
    check("reset_digits", a_dig(), 16'h0000);
    check("reset_flags", {a_run, a_exp, a_tu, a_warn}, 4'b0000);
    check("reset_flags3", {b_run, b_exp, b_tu, b_warn}, 4'b0000);
    reset = 0;
    pulse(1, 0, 0);
    check("start_digits", a_dig(), 16'h0200);
    check("start_running", a_run, 1'b1);
    check("start_warn_120", a_warn, 1'b0);
    check("start3_digits", b_dig(), 16'h0003);
    check("start3_warn", b_warn, 1'b1);
    duty50 = 1; #1;
    check("blink_hi", b_blink, 1'b1);
    check("blink_nowarn", a_blink, 1'b0);
    duty50 = 0; #1;
    check("blink_lo", b_blink, 1'b0);
    ticks(2);
    check("tick2_3s", b_dig(), 16'h0001);
    check("tick2_tu", b_tu, 1'b0);
    ticks(1);
    check("expire_digits", b_dig(), 16'h0000);
    check("expire_flags", {b_run, b_exp, b_tu, b_warn}, 4'b0110);
    check("run_0157", a_dig(), 16'h0157);
    check("run_flags", {a_run, a_tu}, 2'b10);
    @(negedge clk);
    check("time_up_1cyc", b_tu, 1'b0);
    check("expired_hold", b_exp, 1'b1);
    ticks(57);
    check("at_0100", a_dig(), 16'h0100);
    check("expired_frozen", b_dig(), 16'h0000);
    ticks(1);
    check("borrow_0059", a_dig(), 16'h0059);
    pulse(1, 0, 0);
    check("restart_expired3", {b_dig(), 2'(b_run), 2'(b_exp)}, {16'h0003, 2'd1, 2'd0});
    for (int i = 0; i < 96; i++) pulse(0, 1, 0);
    check("at_1000", a_dig(), 16'h1000);
    ticks(1);
    check("borrow_0959", a_dig(), 16'h0959);
    ticks(569);
    check("at_0030", a_dig(), 16'h0030);
    @(negedge clk);
    pause = 1;
    ticks(2);
    check("pause_digits", a_dig(), 16'h0030);
    check("pause_running", a_run, 1'b0);
    check("pause_state", dut.state_q, PAUSED);
    pause = 0;
    @(negedge clk);
    ticks(1);
    check("resume_0029", a_dig(), 16'h0029);
    ticks(18);
    check("warn_at_11", a_warn, 1'b0);
    ticks(1);
    check("warn_at_10", a_warn, 1'b1);
    ticks(2);
    check("at_0008", a_dig(), 16'h0008);
    pulse(0, 1, 1);
    check("bonus_tick_0012", a_dig(), 16'h0012);
    check("bonus_warn_drop", a_warn, 1'b0);
    for (int i = 0; i < 1197; i++) pulse(0, 1, 0);
    check("at_9957", a_dig(), 16'h9957);
    pulse(0, 1, 0);
    check("sat_9959", a_dig(), 16'h9959);
    pulse(0, 1, 0);
    check("sat_hold", a_dig(), 16'h9959);
    pulse(1, 0, 0);
    ticks(75);
    check("at_0045", a_dig(), 16'h0045);
    pulse(1, 0, 0);
    check("restart_mid", {a_dig(), 4'(a_run)}, {16'h0200, 4'd1});
    ticks(4);
    @(negedge clk);
    reset = 1; #1;
    check("async_rst_digits", a_dig(), 16'h0000);
    check("async_rst_flags", {a_run, a_exp, a_tu, a_warn}, 4'b0000);
    @(negedge clk);
    reset = 0;
    pulse(0, 1, 1);
    check("idle_bonus", a_dig(), 16'h0000);
    check("idle_state", dut.state_q, IDLE);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
